// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse-stretcher family: FSM state encoding,
// default parameter values and the shared-counter width helper.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int HOLD_CYC_DEF = 8;
    localparam int GAP_CYC_DEF  = 2;
    localparam int PEND_W_DEF   = 4;

    // Width of the down-counter shared by HIGH and GAP; it must hold max(hold, gap).
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        if (m < 2) return 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_stretch_if.sv
// Request/status bundle between a pulse source and the pulse stretcher.
interface pulse_stretch_if #(
    parameter int PEND_W = 4
) ();
    logic              pulse_in;
    logic              clr_ovf;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;

    modport master (
        output pulse_in, clr_ovf,
        input  level_out, busy, pend_cnt, overflow
    );

    modport slave (
        input  pulse_in, clr_ovf,
        output level_out, busy, pend_cnt, overflow
    );
endinterface

// File: rtl/pulse_stretch.sv
// Stretches single-cycle request pulses into HOLD_CYC-wide level windows separated
// by at least GAP_CYC low cycles, queuing requests that arrive while busy.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int GAP_CYC  = GAP_CYC_DEF,
    parameter int PEND_W   = PEND_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    pulse_stretch_if.slave bus
);

    if (HOLD_CYC < 1 || GAP_CYC < 1) begin : g_param_check
        $error("pulse_stretch: HOLD_CYC and GAP_CYC must both be >= 1");
    end

    localparam int                CNT_W     = cnt_width(HOLD_CYC, GAP_CYC);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PEND_W-1:0] pend_cnt;
    logic              level_q;
    logic              busy_q;
    logic              overflow_q;

    logic last_gap;
    logic deq;
    logic consume;
    logic enq;
    logic drop;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        last_gap = 1'b0;
        deq      = 1'b0;
        consume  = 1'b0;
        enq      = 1'b0;
        drop     = 1'b0;
        last_gap = (state == GAP) && (cnt == '0);
        deq      = last_gap && (pend_cnt != '0);
        consume  = last_gap && (pend_cnt == '0) && bus.pulse_in;
        enq      = bus.pulse_in && (state != IDLE) && !consume;
        drop     = enq && !deq && (pend_cnt == PEND_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_cnt   <= '0;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (enq && !drop && !deq) begin
                pend_cnt <= pend_cnt + PEND_W'(1);
            end else if (deq && !enq) begin
                pend_cnt <= pend_cnt - PEND_W'(1);
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                overflow_q <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (bus.pulse_in) begin
                        state   <= HIGH;
                        cnt     <= HOLD_LOAD;
                        level_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        state   <= GAP;
                        cnt     <= GAP_LOAD;
                        level_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (deq || consume) begin
                        // Final gap edge starts the next window directly: gap is exactly GAP_CYC.
                        state   <= HIGH;
                        cnt     <= HOLD_LOAD;
                        level_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    level_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
    assign bus.pend_cnt  = pend_cnt;
    assign bus.overflow  = overflow_q;

endmodule
